ps2_host_transmitter: RTL and testbench
=======================================

# ps2_host_transmitter

Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, for example 0xED set-LEDs, 0xFF reset and 0xF4 enable. It shares the open-drain `ps2_clock`/`ps2_data` pins with the existing PS/2 keyboard receiver, which stays in the `cpu_clock` domain. The block performs the full host-request sequence: clock inhibit, start bit, device-clocked data, odd parity and stop bit, then checks the device's line-control acknowledge. It reports success or failure with one-cycle pulses.

## Interface
Parameters:
- `inhibit_cycles`, default 5000: `clock` cycles the host holds `ps2_clock` low (100 us at 50 MHz).
- `timeout_cycles`, default 750000: maximum `clock` cycles allowed between successive device falling clock edges, and also for the first edge after the request (15 ms at 50 MHz).

Ports:
- `clock`  in  1  system clock. One clock only; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  command byte; sampled when `tx_valid & tx_ready`.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high only in IDLE; a byte is accepted on any edge where `tx_valid & tx_ready`.
- `tx_done`  out  1  one-cycle pulse: byte sent and ACK bit received as 0.
- `tx_error`  out  1  one-cycle pulse: missing ACK or timeout.
- `busy`  out  1  high in every state except IDLE.
- `ps2_clock_in`  in  1  pad value of the PS/2 clock line (asynchronous).
- `ps2_data_in`  in  1  pad value of the PS/2 data line (asynchronous).
- `ps2_clock_drive_low`  out  1  1 = pull the clock line low, 0 = release it (top level tristates).
- `ps2_data_drive_low`  out  1  1 = pull the data line low, 0 = release it.

## Operation
- Both pad inputs pass through 2-flop synchronizers.
- A falling edge (`fall`) is a synchronized clock value of 1 followed by 0.
- Frame: shift register {stop=1, parity, D7..D0}, sent LSB first.
  - Parity = ~^tx_data (odd parity).
  - Bit counter is 4 bits wide and counts 0..10.
- States:
  - IDLE: both drives 0, `tx_ready`=1. On accept: latch the frame, clear the counter, go to INHIBIT.
  - INHIBIT: `ps2_clock_drive_low`=1 for `inhibit_cycles` cycles. This aborts any in-progress keyboard transmission; the device retransmits it later. Then go to START.
  - START: `ps2_data_drive_low`=1 (start bit 0) and `ps2_clock_drive_low`=0, both in the same cycle. Load the timeout counter and go to BITS.
  - BITS: on each `fall`, `ps2_data_drive_low` becomes ~frame[counter], then counter increments.
    - Falls 1..8 present D0..D7; fall 9 presents parity; fall 10 presents stop, which releases data.
    - After fall 10, go to ACK.
  - ACK: on the next `fall`, sample the synchronized data line.
    - 0 → go to RELEASE with an ok flag.
    - 1 → pulse `tx_error`, go to RELEASE with a fail flag.
  - RELEASE: wait until both synchronized lines read 1.
    - Then pulse `tx_done` if the ok flag is set, and return to IDLE.
    - If this wait exceeds `timeout_cycles`, pulse `tx_error` (failed transfers produce one pulse only) and go to IDLE.
- Timeout counter:
  - Width is $clog2(timeout_cycles+1).
  - Reloaded on entry to START and on every `fall` in BITS/ACK.
  - Reaching 0 in BITS or ACK: release both lines, pulse `tx_error`, go to IDLE.
- `tx_valid` while busy is ignored; no queueing.
- Outputs `tx_done` and `tx_error` are never high together.

## Timing
- Reset values: `tx_ready`=1; `tx_done`=`tx_error`=`busy`=0; both drive outputs 0. Internal state: IDLE.
- Reset mid-operation releases both lines immediately (asynchronous) and does not pulse `tx_done` or `tx_error`.
- Every output is a registered flop output.
- Accept edge → `ps2_clock_drive_low` high on the following cycle; `busy` rises on the same edge.
- Clock held low for exactly `inhibit_cycles` cycles. The data pull-down asserts on the cycle the clock is released.
- Pad falling edge → `fall` 2-3 cycles later. Data changes one cycle after `fall`, well within the device's clock-low half period (≥ 30 us).
- `tx_done` is asserted 1 cycle after both lines read high in RELEASE. `tx_ready` returns the cycle after the pulse.

## Test plan
Bench parameters: `inhibit_cycles`=20, `timeout_cycles`=2000. The device model clocks at a 200-cycle period, samples data on rising edges, then ACKs.
- Send 0xED → clock held low for 20 cycles, then start bit 0. Device samples 1,0,1,1,0,1,1,1, then parity 1, then stop 1. Model ACKs 0 → one `tx_done` pulse, `tx_ready` returns to 1.
- Send 0x00 then 0x01 back to back, with `tx_valid` held → parity 1 then parity 0. Second byte accepted only after the first `tx_done`.
- Send 0xFF with the model not pulling data low on the 11th clock → one `tx_error` pulse, no `tx_done`, lines released.
- Model never clocks after the request → `tx_error` pulse 2000 cycles after START entry; both drives 0.
- Model stops after 5 bits → `tx_error` 2000 cycles after the 5th fall; IDLE afterwards.
- Assert `reset` during bit 4 of 0xF4 → both drives 0 immediately. `tx_ready`=1, no pulses. A following send of 0xF4 succeeds.

Source files
------------

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, start bit, device-clocked data,
// odd parity and stop, then the device's line-control acknowledge.
`timescale 1ns/1ps
module ps2_host_transmitter #(
  parameter int inhibit_cycles = 5000,
  parameter int timeout_cycles = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int timeout_w = $clog2(timeout_cycles + 1);
  localparam int inhibit_w = (inhibit_cycles > 1) ? $clog2(inhibit_cycles) : 1;
  localparam logic [timeout_w-1:0] timeout_load = timeout_w'(timeout_cycles);
  localparam logic [inhibit_w-1:0] inhibit_load = inhibit_w'(inhibit_cycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK,
    RELEASE
  } state_t;

  state_t               state_reg, state_next;
  logic [9:0]           frame_reg, frame_next;
  logic [3:0]           bit_count_reg, bit_count_next;
  logic [inhibit_w-1:0] inhibit_count_reg, inhibit_count_next;
  logic [timeout_w-1:0] timeout_count_reg, timeout_count_next;
  logic                 ok_reg, ok_next;
  logic                 tx_ready_next, tx_done_next, tx_error_next, busy_next;
  logic                 clock_drive_next, data_drive_next;

  logic clock_meta_reg, clock_sync_reg, clock_prev_reg;
  logic data_meta_reg, data_sync_reg;
  logic fall;

  // Idle-high pads, so the synchronizers reset to 1 to avoid a spurious edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clock_meta_reg <= 1'b1;
      clock_sync_reg <= 1'b1;
      clock_prev_reg <= 1'b1;
      data_meta_reg  <= 1'b1;
      data_sync_reg  <= 1'b1;
    end else begin
      clock_meta_reg <= ps2_clock_in;
      clock_sync_reg <= clock_meta_reg;
      clock_prev_reg <= clock_sync_reg;
      data_meta_reg  <= ps2_data_in;
      data_sync_reg  <= data_meta_reg;
    end
  end

  assign fall = clock_prev_reg & ~clock_sync_reg;

  always_comb begin
    state_next         = state_reg;
    frame_next         = frame_reg;
    bit_count_next     = bit_count_reg;
    inhibit_count_next = inhibit_count_reg;
    timeout_count_next = timeout_count_reg;
    ok_next            = ok_reg;
    clock_drive_next   = ps2_clock_drive_low;
    data_drive_next    = ps2_data_drive_low;
    tx_done_next       = 1'b0;
    tx_error_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        clock_drive_next = 1'b0;
        data_drive_next  = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_next         = {1'b1, ~^tx_data, tx_data};
          bit_count_next     = 4'd0;
          inhibit_count_next = inhibit_load;
          ok_next            = 1'b0;
          clock_drive_next   = 1'b1;
          state_next         = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inhibit_count_reg == '0) begin
          clock_drive_next = 1'b0;
          data_drive_next  = 1'b1;
          state_next       = START;
        end else begin
          inhibit_count_next = inhibit_count_reg - inhibit_w'(1);
        end
      end
      START: begin
        timeout_count_next = timeout_load;
        state_next         = BITS;
      end
      BITS: begin
        if (fall) begin
          // Frame shifts out LSB first; stop bit (1) releases the data line.
          data_drive_next    = ~frame_reg[0];
          frame_next         = {1'b1, frame_reg[9:1]};
          bit_count_next     = bit_count_reg + 4'd1;
          timeout_count_next = timeout_load;
          if (bit_count_reg == 4'd9) state_next = ACK;
        end else if (timeout_count_reg == '0) begin
          clock_drive_next = 1'b0;
          data_drive_next  = 1'b0;
          tx_error_next    = 1'b1;
          state_next       = IDLE;
        end else begin
          timeout_count_next = timeout_count_reg - timeout_w'(1);
        end
      end
      ACK: begin
        if (fall) begin
          timeout_count_next = timeout_load;
          state_next         = RELEASE;
          ok_next            = ~data_sync_reg;
          tx_error_next      = data_sync_reg;
        end else if (timeout_count_reg == '0) begin
          clock_drive_next = 1'b0;
          data_drive_next  = 1'b0;
          tx_error_next    = 1'b1;
          state_next       = IDLE;
        end else begin
          timeout_count_next = timeout_count_reg - timeout_w'(1);
        end
      end
      RELEASE: begin
        clock_drive_next = 1'b0;
        data_drive_next  = 1'b0;
        if (clock_sync_reg && data_sync_reg) begin
          tx_done_next = ok_reg;
          state_next   = IDLE;
        end else if (timeout_count_reg == '0) begin
          // A NACKed transfer already reported its error.
          tx_error_next = ok_reg;
          state_next    = IDLE;
        end else begin
          timeout_count_next = timeout_count_reg - timeout_w'(1);
        end
      end
      default: begin
        clock_drive_next = 1'b0;
        data_drive_next  = 1'b0;
        state_next       = IDLE;
      end
    endcase

    busy_next     = (state_next != IDLE);
    tx_ready_next = (state_reg == IDLE) && (state_next == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg           <= IDLE;
      frame_reg           <= '0;
      bit_count_reg       <= '0;
      inhibit_count_reg   <= '0;
      timeout_count_reg   <= '0;
      ok_reg              <= 1'b0;
      tx_ready            <= 1'b1;
      tx_done             <= 1'b0;
      tx_error            <= 1'b0;
      busy                <= 1'b0;
      ps2_clock_drive_low <= 1'b0;
      ps2_data_drive_low  <= 1'b0;
    end else begin
      state_reg           <= state_next;
      frame_reg           <= frame_next;
      bit_count_reg       <= bit_count_next;
      inhibit_count_reg   <= inhibit_count_next;
      timeout_count_reg   <= timeout_count_next;
      ok_reg              <= ok_next;
      tx_ready            <= tx_ready_next;
      tx_done             <= tx_done_next;
      tx_error            <= tx_error_next;
      busy                <= busy_next;
      ps2_clock_drive_low <= clock_drive_next;
      ps2_data_drive_low  <= data_drive_next;
    end
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;

  localparam int INH = 20;
  localparam int TMO = 2000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clock_drive_low, ps2_data_drive_low;
  logic       ps2_clock_in, ps2_data_in;
  logic       dev_clock = 1'b1;
  logic       dev_data = 1'b1;

  // Open-drain lines: host and device can each only pull low.
  assign ps2_clock_in = ~ps2_clock_drive_low & dev_clock;
  assign ps2_data_in  = ~ps2_data_drive_low & dev_data;

  ps2_host_transmitter #(
    .inhibit_cycles(INH),
    .timeout_cycles(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .busy(busy),
    .ps2_clock_in(ps2_clock_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clock_drive_low(ps2_clock_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int error_count = 0;
  int both_count = 0;
  int err_cyc = 0;
  int done_cyc = 0;
  int inhibit_rise_cyc = 0;
  logic clock_drive_prev = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (tx_done) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
    end
    if (tx_error) begin
      error_count <= error_count + 1;
      err_cyc     <= cyc;
    end
    if (tx_done && tx_error) both_count <= both_count + 1;
    if (ps2_clock_drive_low && !clock_drive_prev) inhibit_rise_cyc <= cyc;
    clock_drive_prev <= ps2_clock_drive_low;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic accept_byte(input logic [7:0] b, input bit hold, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (tx_ready) ok = 1'b1;
      else @(negedge clock);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_request(output int inhibit_len, output int start_cyc, output bit ok);
    inhibit_len = 0;
    start_cyc   = 0;
    ok          = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (ps2_data_drive_low && !ps2_clock_drive_low) begin
        ok        = 1'b1;
        start_cyc = cyc;
      end else begin
        if (ps2_clock_drive_low) inhibit_len++;
        @(negedge clock);
      end
    end
  endtask

  // Device clocks at a 200-cycle period, sampling data on rising edges; clock 11 is the ACK.
  task automatic device_run(input int n_clocks, input bit ack, output logic [9:0] seen,
                            output int last_fall_cyc);
    seen          = '0;
    last_fall_cyc = 0;
    cycles(20);
    for (int k = 1; k <= n_clocks; k++) begin
      if (k == 11) begin
        dev_data = ack ? 1'b0 : 1'b1;
        cycles(5);
      end
      dev_clock     = 1'b0;
      last_fall_cyc = cyc;
      cycles(100);
      dev_clock = 1'b1;
      if (k <= 10) seen[k-1] = ps2_data_in;
      if (k == 11) begin
        dev_data = 1'b1;
        cycles(10);
      end else begin
        cycles(100);
      end
    end
  endtask

  task automatic wait_error(input int snap, output bit found);
    found = 1'b0;
    for (int i = 0; i < 2600 && !found; i++) begin
      @(negedge clock);
      if (error_count > snap) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    cycles(3);
    checks++;
    if ({tx_ready, tx_done, tx_error, busy, ps2_clock_drive_low, ps2_data_drive_low} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 100000",
               {tx_ready, tx_done, tx_error, busy, ps2_clock_drive_low, ps2_data_drive_low});
    end
    reset = 1'b0;
    cycles(3);
    checks++;
    if ({tx_ready, tx_done, tx_error, busy, ps2_clock_drive_low, ps2_data_drive_low} !== 6'b100000) begin
      errors++;
      $display("FAIL idle_outputs got %b want 100000",
               {tx_ready, tx_done, tx_error, busy, ps2_clock_drive_low, ps2_data_drive_low});
    end
  endtask

  task automatic test_send_ed;
    bit ok_a, ok_r;
    int inh, sc, lf;
    int d0, e0;
    logic [9:0] seen;
    d0 = done_count;
    e0 = error_count;
    accept_byte(8'hED, 1'b0, ok_a);
    checks++;
    if (!(ok_a && busy && ps2_clock_drive_low && !tx_ready)) begin
      errors++;
      $display("FAIL ed_accept got ok=%0b busy=%0b clk_low=%0b ready=%0b want 1 1 1 0",
               ok_a, busy, ps2_clock_drive_low, tx_ready);
    end
    wait_request(inh, sc, ok_r);
    checks++;
    if (!ok_r || inh != INH) begin
      errors++;
      $display("FAIL ed_inhibit_len got %0d (req=%0b) want %0d", inh, ok_r, INH);
    end
    checks++;
    if (ps2_data_in !== 1'b0) begin
      errors++;
      $display("FAIL ed_start_bit got %b want 0", ps2_data_in);
    end
    device_run(11, 1'b1, seen, lf);
    checks++;
    if (seen !== 10'b11_1110_1101) begin
      errors++;
      $display("FAIL ed_frame got %b want 1111101101", seen);
    end
    checks++;
    if (done_count - d0 != 1 || error_count - e0 != 0) begin
      errors++;
      $display("FAIL ed_pulses got done=%0d err=%0d want 1 0", done_count - d0, error_count - e0);
    end
    checks++;
    if ({tx_ready, busy, ps2_clock_drive_low, ps2_data_drive_low} !== 4'b1000) begin
      errors++;
      $display("FAIL ed_back_idle got %b want 1000",
               {tx_ready, busy, ps2_clock_drive_low, ps2_data_drive_low});
    end
  endtask

  task automatic test_back_to_back;
    bit ok_a, ok_r, seen_second;
    int inh, sc, lf;
    int d0;
    logic [9:0] seen0, seen1;
    d0 = done_count;
    accept_byte(8'h00, 1'b1, ok_a);
    tx_data = 8'h01;
    wait_request(inh, sc, ok_r);
    device_run(11, 1'b1, seen0, lf);
    seen_second = 1'b0;
    for (int i = 0; i < 100 && !seen_second; i++) begin
      if (ps2_clock_drive_low) seen_second = 1'b1;
      else @(negedge clock);
    end
    cycles(1);
    tx_valid = 1'b0;
    checks++;
    if (!ok_a || !seen_second || done_count - d0 != 1 || !(done_cyc < inhibit_rise_cyc)) begin
      errors++;
      $display("FAIL b2b_second_after_done got second=%0b done=%0d done_cyc=%0d inhibit_cyc=%0d want second after 1 done",
               seen_second, done_count - d0, done_cyc, inhibit_rise_cyc);
    end
    checks++;
    if (seen0 !== 10'b11_0000_0000) begin
      errors++;
      $display("FAIL b2b_frame0 got %b want 1100000000", seen0);
    end
    wait_request(inh, sc, ok_r);
    checks++;
    if (!ok_r) begin
      errors++;
      $display("FAIL b2b_request got 0 want 1");
    end
    device_run(11, 1'b1, seen1, lf);
    checks++;
    if (seen1 !== 10'b10_0000_0001) begin
      errors++;
      $display("FAIL b2b_frame1 got %b want 1000000001", seen1);
    end
    checks++;
    if (done_count - d0 != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d want 2", done_count - d0);
    end
  endtask

  task automatic test_no_ack;
    bit ok_a, ok_r;
    int inh, sc, lf;
    int d0, e0;
    logic [9:0] seen;
    d0 = done_count;
    e0 = error_count;
    accept_byte(8'hFF, 1'b0, ok_a);
    wait_request(inh, sc, ok_r);
    device_run(11, 1'b0, seen, lf);
    checks++;
    if (!ok_a || !ok_r || seen !== 10'b11_1111_1111) begin
      errors++;
      $display("FAIL nack_frame got %b want 1111111111", seen);
    end
    checks++;
    if (error_count - e0 != 1 || done_count - d0 != 0) begin
      errors++;
      $display("FAIL nack_pulses got err=%0d done=%0d want 1 0", error_count - e0, done_count - d0);
    end
    checks++;
    if ({busy, ps2_clock_drive_low, ps2_data_drive_low} !== 3'b000) begin
      errors++;
      $display("FAIL nack_released got %b want 000", {busy, ps2_clock_drive_low, ps2_data_drive_low});
    end
  endtask

  task automatic test_no_clock;
    bit ok_a, ok_r, found;
    int inh, sc;
    int d0, e0;
    d0 = done_count;
    e0 = error_count;
    accept_byte(8'h55, 1'b0, ok_a);
    wait_request(inh, sc, ok_r);
    wait_error(e0, found);
    checks++;
    if (!found || !ok_r || err_cyc - sc < TMO || err_cyc - sc > TMO + 4) begin
      errors++;
      $display("FAIL noclk_timeout got found=%0b delay=%0d want %0d..%0d",
               found, err_cyc - sc, TMO, TMO + 4);
    end
    checks++;
    if ({busy, ps2_clock_drive_low, ps2_data_drive_low} !== 3'b000) begin
      errors++;
      $display("FAIL noclk_released got %b want 000", {busy, ps2_clock_drive_low, ps2_data_drive_low});
    end
    checks++;
    if (error_count - e0 != 1 || done_count - d0 != 0) begin
      errors++;
      $display("FAIL noclk_pulses got err=%0d done=%0d want 1 0", error_count - e0, done_count - d0);
    end
  endtask

  task automatic test_stall;
    bit ok_a, ok_r, found;
    int inh, sc, lf;
    int e0;
    logic [9:0] seen;
    e0 = error_count;
    accept_byte(8'h3C, 1'b0, ok_a);
    wait_request(inh, sc, ok_r);
    device_run(5, 1'b1, seen, lf);
    checks++;
    if (seen[4:0] !== 5'b11100) begin
      errors++;
      $display("FAIL stall_bits got %b want 11100", seen[4:0]);
    end
    wait_error(e0, found);
    checks++;
    if (!found || err_cyc - lf < TMO || err_cyc - lf > TMO + 8) begin
      errors++;
      $display("FAIL stall_timeout got found=%0b delay=%0d want %0d..%0d",
               found, err_cyc - lf, TMO, TMO + 8);
    end
    cycles(1);
    checks++;
    if ({tx_ready, busy, ps2_clock_drive_low, ps2_data_drive_low} !== 4'b1000) begin
      errors++;
      $display("FAIL stall_idle got %b want 1000",
               {tx_ready, busy, ps2_clock_drive_low, ps2_data_drive_low});
    end
  endtask

  task automatic test_reset_mid;
    bit ok_a, ok_r;
    int inh, sc, lf;
    int d0, e0;
    logic [9:0] seen;
    d0 = done_count;
    e0 = error_count;
    accept_byte(8'hF4, 1'b0, ok_a);
    wait_request(inh, sc, ok_r);
    device_run(4, 1'b1, seen, lf);
    checks++;
    if (!busy) begin
      errors++;
      $display("FAIL rst_mid_busy got %b want 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_ready, busy, ps2_clock_drive_low, ps2_data_drive_low} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_async got %b want 1000",
               {tx_ready, busy, ps2_clock_drive_low, ps2_data_drive_low});
    end
    cycles(2);
    reset = 1'b0;
    cycles(3);
    checks++;
    if (done_count - d0 != 0 || error_count - e0 != 0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_quiet got done=%0d err=%0d ready=%b want 0 0 1",
               done_count - d0, error_count - e0, tx_ready);
    end
    accept_byte(8'hF4, 1'b0, ok_a);
    wait_request(inh, sc, ok_r);
    device_run(11, 1'b1, seen, lf);
    checks++;
    if (!ok_r || seen !== 10'b10_1111_0100) begin
      errors++;
      $display("FAIL rst_mid_resend_frame got %b want 1011110100", seen);
    end
    checks++;
    if (done_count - d0 != 1 || error_count - e0 != 0) begin
      errors++;
      $display("FAIL rst_mid_resend_pulses got done=%0d err=%0d want 1 0",
               done_count - d0, error_count - e0);
    end
  endtask

  task automatic test_exclusive_pulses;
    checks++;
    if (both_count != 0) begin
      errors++;
      $display("FAIL pulses_exclusive got %0d overlaps want 0", both_count);
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_no_ack();
    test_no_clock();
    test_stall();
    test_reset_mid();
    test_exclusive_pulses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
